phys_reg_free_list: RTL and testbench

Physical-register free list for the rename stage. It hands out up to four free physical register tags per cycle to the RAT/BusyTable path and accepts up to four released tags per cycle from commit. It keeps a speculative allocation head and a committed head so that a pipeline flush reclaims every tag allocated after the last commit in one cycle. It sits between the rename stage (requesters) and the ROB commit logic (releaser), and owns the 128-entry physical register space alongside BusyTable.

---
 rtl/phys_reg_free_list_if.sv | 34 +++
 rtl/phys_reg_free_list.sv | 98 +++++++++
 tb/tb_phys_reg_free_list.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit <-> free-list bus: allocation requests and grants, commit and release traffic.
// The rename/commit side uses the master modport; the free list uses the slave modport.
interface phys_reg_free_list_if #(
  parameter int TAG_W = 7,
  parameter int CNT_W = TAG_W + 1
);
  logic             AllocReq1, AllocReq2, AllocReq3, AllocReq4;
  logic [TAG_W-1:0] AllocAddr1, AllocAddr2, AllocAddr3, AllocAddr4;
  logic             AllocGrant;
  logic             FreeStop;
  logic             FreeFlash;
  logic [2:0]       CommitNum;
  logic             FreeAble1, FreeAble2, FreeAble3, FreeAble4;
  logic [TAG_W-1:0] FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4;
  logic [CNT_W-1:0] FreeCount;

  modport master (
    output AllocReq1, AllocReq2, AllocReq3, AllocReq4,
    input  AllocAddr1, AllocAddr2, AllocAddr3, AllocAddr4, AllocGrant,
    output FreeStop, FreeFlash, CommitNum,
    output FreeAble1, FreeAble2, FreeAble3, FreeAble4,
    output FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
    input  FreeCount
  );

  modport slave (
    input  AllocReq1, AllocReq2, AllocReq3, AllocReq4,
    output AllocAddr1, AllocAddr2, AllocAddr3, AllocAddr4, AllocGrant,
    input  FreeStop, FreeFlash, CommitNum,
    input  FreeAble1, FreeAble2, FreeAble3, FreeAble4,
    input  FreeAddr1, FreeAddr2, FreeAddr3, FreeAddr4,
    output FreeCount
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with a speculative and a committed head,
// so a flush rewinds every allocation made since the last commit in a single cycle.
module phys_reg_free_list #(
  parameter int PREG_NUM = 128,
  parameter int AREG_NUM = 32
) (
  input logic                Clk,
  input logic                Rest,
  phys_reg_free_list_if.slave fl
);
  localparam int PTR_W     = $clog2(PREG_NUM);
  localparam int CNT_W     = PTR_W + 1;
  localparam int INIT_FREE = PREG_NUM - AREG_NUM;

  logic [PTR_W-1:0] fifo [PREG_NUM];
  logic [PTR_W-1:0] spec_head, commit_head, tail;
  logic [CNT_W-1:0] count;

  logic [3:0]       req, fre;
  logic [2:0]       nreq, nfree;
  logic [PTR_W-1:0] aoff [4];
  logic [PTR_W-1:0] foff [4];
  logic [PTR_W-1:0] faddr [4];
  logic [PTR_W-1:0] commit_next, tail_next;
  logic             grant;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  // Number of asserted bits strictly below slot n.
  function automatic logic [PTR_W-1:0] prefix(input logic [3:0] v, input int n);
    logic [PTR_W-1:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n && v[i]) c = c + 1'b1;
    end
    return c;
  endfunction

  assign req   = {fl.AllocReq4, fl.AllocReq3, fl.AllocReq2, fl.AllocReq1};
  assign fre   = {fl.FreeAble4, fl.FreeAble3, fl.FreeAble2, fl.FreeAble1};
  assign nreq  = popcnt4(req);
  assign nfree = popcnt4(fre);

  assign faddr[0] = fl.FreeAddr1;
  assign faddr[1] = fl.FreeAddr2;
  assign faddr[2] = fl.FreeAddr3;
  assign faddr[3] = fl.FreeAddr4;

  // Requesting slots are compacted onto consecutive entries; idle slots show
  // entry SpecHead+N-1 so their output is a stable function of state and inputs.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      aoff[n] = req[n] ? prefix(req, n) : PTR_W'(n);
      foff[n] = prefix(fre, n);
    end
  end

  assign fl.AllocAddr1 = fifo[spec_head + aoff[0]];
  assign fl.AllocAddr2 = fifo[spec_head + aoff[1]];
  assign fl.AllocAddr3 = fifo[spec_head + aoff[2]];
  assign fl.AllocAddr4 = fifo[spec_head + aoff[3]];

  assign grant         = (nreq != 3'd0) && !fl.FreeStop && !fl.FreeFlash
                         && (count >= CNT_W'(nreq));
  assign fl.AllocGrant = grant;
  assign fl.FreeCount  = count;

  assign commit_next = commit_head + PTR_W'(fl.CommitNum);
  assign tail_next   = tail + PTR_W'(nfree);

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < PREG_NUM; i++) begin
        fifo[i] <= (i < INIT_FREE) ? PTR_W'(AREG_NUM + i) : '0;
      end
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(INIT_FREE);
      count       <= CNT_W'(INIT_FREE);
    end else begin
      // Releases land in slot order and are never blocked by stall or flush.
      for (int n = 0; n < 4; n++) begin
        if (fre[n]) fifo[tail + foff[n]] <= faddr[n];
      end
      tail        <= tail_next;
      commit_head <= commit_next;
      if (fl.FreeFlash) begin
        spec_head <= commit_next;
        count     <= {1'b0, PTR_W'(tail_next - commit_next)};
      end else begin
        if (grant) spec_head <= spec_head + PTR_W'(nreq);
        count <= count - (grant ? CNT_W'(nreq) : '0) + CNT_W'(nfree);
      end
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: a vector table plus hand-written
// sequences for exhaustion, flush recovery, pointer wrap and async reset.
module tb_phys_reg_free_list;
  logic Clk = 1'b0;
  logic Rest = 1'b0;
  int   errors = 0;
  int   checks = 0;

  phys_reg_free_list_if #(.TAG_W(7)) bus ();

  phys_reg_free_list #(.PREG_NUM(128), .AREG_NUM(32)) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .fl   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] req;
    logic       stop;
    logic       flash;
    logic [2:0] cnum;
    logic [3:0] fre;
    int         f1, f2, f3, f4;
    logic       g;
    int         e1, e2, e3, e4;
    int         cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic stop, input logic flash,
                       input logic [2:0] cnum, input logic [3:0] fre,
                       input int f1, input int f2, input int f3, input int f4);
    bus.AllocReq1 = req[0];
    bus.AllocReq2 = req[1];
    bus.AllocReq3 = req[2];
    bus.AllocReq4 = req[3];
    bus.FreeStop  = stop;
    bus.FreeFlash = flash;
    bus.CommitNum = cnum;
    bus.FreeAble1 = fre[0];
    bus.FreeAble2 = fre[1];
    bus.FreeAble3 = fre[2];
    bus.FreeAble4 = fre[3];
    bus.FreeAddr1 = 7'(f1);
    bus.FreeAddr2 = 7'(f2);
    bus.FreeAddr3 = 7'(f3);
    bus.FreeAddr4 = 7'(f4);
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    idle();
    Rest = 1'b0;
    #2;
    Rest = 1'b1;
  endtask

  initial begin
    int q[$];
    int prev[4];
    int cur[4];

    // req/stop/flash/cnum/fre/f1..f4 -> grant, AllocAddr1..4, FreeCount
    vecs[0] = '{4'b0000, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 32, 33, 34, 35, 96};
    vecs[1] = '{4'b1111, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 32, 33, 34, 35, 96};
    vecs[2] = '{4'b0000, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 36, 37, 38, 39, 92};
    vecs[3] = '{4'b1010, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 36, 36, 38, 37, 92};
    vecs[4] = '{4'b0001, 1, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 38, 39, 40, 41, 90};
    vecs[5] = '{4'b1111, 0, 0, 3'd0, 4'b0101, 32, 0, 33, 0, 1, 38, 39, 40, 41, 90};
    vecs[6] = '{4'b0000, 0, 0, 3'd3, 4'b0000, 0, 0, 0, 0, 0, 42, 43, 44, 45, 88};
    vecs[7] = '{4'b1111, 0, 1, 3'd1, 4'b0000, 0, 0, 0, 0, 0, 42, 43, 44, 45, 88};
    vecs[8] = '{4'b0001, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 36, 37, 38, 39, 94};
    vecs[9] = '{4'b0000, 0, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 0, 37, 38, 39, 40, 93};

    idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      drive(vecs[i].req, vecs[i].stop, vecs[i].flash, vecs[i].cnum, vecs[i].fre,
            vecs[i].f1, vecs[i].f2, vecs[i].f3, vecs[i].f4);
      #1;
      chk($sformatf("vec%0d grant", i), int'(bus.AllocGrant), int'(vecs[i].g));
      chk($sformatf("vec%0d addr1", i), int'(bus.AllocAddr1), vecs[i].e1);
      chk($sformatf("vec%0d addr2", i), int'(bus.AllocAddr2), vecs[i].e2);
      chk($sformatf("vec%0d addr3", i), int'(bus.AllocAddr3), vecs[i].e3);
      chk($sformatf("vec%0d addr4", i), int'(bus.AllocAddr4), vecs[i].e4);
      chk($sformatf("vec%0d count", i), int'(bus.FreeCount), vecs[i].cnt);
    end

    // Sparse requests compact onto consecutive entries.
    do_reset();
    @(negedge Clk);
    drive(4'b1010, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    #1;
    chk("sparse grant", int'(bus.AllocGrant), 1);
    chk("sparse addr2", int'(bus.AllocAddr2), 32);
    chk("sparse addr4", int'(bus.AllocAddr4), 33);
    @(negedge Clk);
    idle();
    #1;
    chk("sparse count", int'(bus.FreeCount), 94);

    // Drain to empty, request while a free arrives in the same cycle.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge Clk);
      drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    end
    @(negedge Clk);
    drive(4'b0001, 1'b0, 1'b0, 3'd0, 4'b0001, 40, 0, 0, 0);
    #1;
    chk("empty count", int'(bus.FreeCount), 0);
    chk("empty grant", int'(bus.AllocGrant), 0);
    @(negedge Clk);
    drive(4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    #1;
    chk("refill count", int'(bus.FreeCount), 1);
    chk("refill addr1", int'(bus.AllocAddr1), 40);
    chk("refill grant", int'(bus.AllocGrant), 1);
    @(negedge Clk);
    drive(4'b0011, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    #1;
    chk("redrain count", int'(bus.FreeCount), 0);
    chk("redrain grant", int'(bus.AllocGrant), 0);

    // Flush after a partial commit rewinds the speculative head.
    do_reset();
    @(negedge Clk);
    drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    @(negedge Clk);
    drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
    @(negedge Clk);
    drive(4'b0000, 1'b0, 1'b0, 3'd3, 4'b0000, 0, 0, 0, 0);
    @(negedge Clk);
    drive(4'b0001, 1'b0, 1'b1, 3'd0, 4'b0000, 0, 0, 0, 0);
    #1;
    chk("flush grant", int'(bus.AllocGrant), 0);
    chk("flush pre count", int'(bus.FreeCount), 88);
    @(negedge Clk);
    idle();
    #1;
    chk("flush count", int'(bus.FreeCount), 93);
    chk("flush addr1", int'(bus.AllocAddr1), 35);

    // Steady 4-wide alloc/free across the 127->0 wrap of both pointers.
    do_reset();
    q.delete();
    for (int t = 32; t < 128; t++) q.push_back(t);
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (c == 0) drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b0000, 0, 0, 0, 0);
      else        drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b1111, prev[0], prev[1], prev[2], prev[3]);
      #1;
      for (int n = 0; n < 4; n++) cur[n] = q.pop_front();
      chk($sformatf("wrap%0d grant", c), int'(bus.AllocGrant), 1);
      chk($sformatf("wrap%0d addr1", c), int'(bus.AllocAddr1), cur[0]);
      chk($sformatf("wrap%0d addr2", c), int'(bus.AllocAddr2), cur[1]);
      chk($sformatf("wrap%0d addr3", c), int'(bus.AllocAddr3), cur[2]);
      chk($sformatf("wrap%0d addr4", c), int'(bus.AllocAddr4), cur[3]);
      chk($sformatf("wrap%0d count", c), int'(bus.FreeCount), (c == 0) ? 96 : 92);
      if (c != 0) for (int n = 0; n < 4; n++) q.push_back(prev[n]);
      for (int n = 0; n < 4; n++) prev[n] = cur[n];
    end

    // Async reset mid-burst: state returns before any further clock edge.
    @(negedge Clk);
    drive(4'b1111, 1'b0, 1'b0, 3'd0, 4'b1111, prev[0], prev[1], prev[2], prev[3]);
    #1;
    Rest = 1'b0;
    #1;
    chk("areset count", int'(bus.FreeCount), 96);
    chk("areset addr1", int'(bus.AllocAddr1), 32);
    chk("areset addr2", int'(bus.AllocAddr2), 33);
    chk("areset addr3", int'(bus.AllocAddr3), 34);
    chk("areset addr4", int'(bus.AllocAddr4), 35);
    idle();
    #1;
    chk("areset grant", int'(bus.AllocGrant), 0);
    Rest = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
